// File: rtl/mult_div_if.sv
// mult_div_if
//   Request/result bundle between the EX stage and the multiply/divide unit.
//   master : EX-stage side, drives the operands and the request strobe.
//   slave  : mult_div_unit, returns busy/stall status and the HI/LO registers.
//
//   MD_A     [31:0] operand rs (dividend / multiplicand / MTHI-MTLO source)
//   MD_B     [31:0] operand rt (divisor / multiplier)
//   MD_Op    [2:0]  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   MD_Start        request strobe for MD_Op this cycle
//   MD_Busy         registered, high while an operation is in flight
//   MD_Stall        combinational, MD_Busy | (MD_Start & MD_Op <= 3)
//   HI, LO   [31:0] architectural HI/LO registers
interface mult_div_if;
  logic [31:0] MD_A;
  logic [31:0] MD_B;
  logic [2:0]  MD_Op;
  logic        MD_Start;
  logic        MD_Busy;
  logic        MD_Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MD_A, MD_B, MD_Op, MD_Start,
    input  MD_Busy, MD_Stall, HI, LO
  );

  modport slave (
    input  MD_A, MD_B, MD_Op, MD_Start,
    output MD_Busy, MD_Stall, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers for the
//   pipelined MIPS core. The result is computed from the operands present in
//   the Start cycle and held in pending registers; HI/LO are only written once
//   the busy countdown expires, so the architectural view matches an
//   iterative unit of the same latency. MTHI/MTLO write in a single cycle.
//
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   md     mult_div_if.slave (operands, op, start, busy, stall, HI, LO)
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mult_div_if.slave    md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_we;   // cleared for divide by zero: HI/LO keep old values

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated on the live operands; only consumed in the Start cycle
  // ---------------------------------------------------------------------------
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        b_zero;

  assign a      = md.MD_A;
  assign b      = md.MD_B;
  assign b_zero = (b == 32'd0);

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply
  // equal to the two's-complement signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division through magnitudes: quotient negated when the operand
  // signs differ, remainder takes the dividend's sign. 0x80000000 / -1 falls
  // out naturally as magnitude 0x80000000, which negates to itself.
  assign abs_a  = a[31] ? (~a + 32'd1) : a;
  assign abs_b  = b[31] ? (~b + 32'd1) : b;
  // Divisor forced to 1 on zero so no X leaks; the result is discarded anyway.
  assign div_b  = b_zero ? 32'd1 : b;
  assign sq_mag = abs_a / (b_zero ? 32'd1 : abs_b);
  assign sr_mag = abs_a % (b_zero ? 32'd1 : abs_b);
  assign uq     = a / div_b;
  assign ur     = a % div_b;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a value unassigned and infers a latch.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_we = 1'b1;
    unique case (md.MD_Op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
        res_hi = a[31] ? (~sr_mag + 32'd1) : sr_mag;
        res_we = !b_zero;
      end
      OP_DIVU: begin
        res_lo = uq;
        res_hi = ur;
        res_we = !b_zero;
      end
      default: res_we = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic          start_md;
  logic [CW-1:0] load_cnt;

  assign start_md = md.MD_Start && (md.MD_Op <= OP_DIVU);
  // Op bit 1 separates the divides (2,3) from the multiplies (0,1).
  assign load_cnt = md.MD_Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_md) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_we <= res_we;
            cnt     <= load_cnt;
            busy_q  <= 1'b1;
            state   <= BUSY;
          end else if (md.MD_Start && md.MD_Op == OP_MTHI) begin
            hi_q <= a;
          end else if (md.MD_Start && md.MD_Op == OP_MTLO) begin
            lo_q <= a;
          end
        end
        BUSY: begin
          // Requests during BUSY, including MTHI/MTLO, are ignored outright.
          if (cnt == CW'(1)) begin
            if (pend_we) begin
              hi_q <= pend_hi;
              lo_q <= pend_lo;
            end
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.MD_Busy  = busy_q;
  assign md.MD_Stall = busy_q | start_md;
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed, table-driven bench for mult_div_unit. Inputs are driven and
//   outputs sampled on the falling edge. Each table row is issued the first
//   cycle after the previous one finishes, so the rows also exercise
//   back-to-back issue. Hand-written sequences cover requests during BUSY,
//   mid-op operand changes and reset mid-operation.
module tb_mult_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int BUSY_LIMIT  = 40;

  logic clk;
  logic reset;

  mult_div_if md ();

  mult_div_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  // Expected architectural HI/LO, maintained by the bench.
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    md.MD_Start = 1'b0;
    md.MD_Op    = 3'd7;
    md.MD_A     = $urandom;
    md.MD_B     = $urandom;
  endtask

  // Called on a falling edge; returns on the falling edge of the first cycle
  // with MD_Busy low, so the next call issues back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_cyc);
    int n;
    md.MD_Op    = op;
    md.MD_A     = a;
    md.MD_B     = b;
    md.MD_Start = 1'b1;
    #1;
    check({tag, " start stall"}, {31'd0, md.MD_Stall}, {31'd0, (op <= 3'd3)});
    check({tag, " start busy"}, {31'd0, md.MD_Busy}, 32'd0);
    @(negedge clk);
    idle_inputs();   // scrambled operands must not affect the pending result
    n = 0;
    while (md.MD_Busy && n < BUSY_LIMIT) begin
      check({tag, " hi during busy"}, md.HI, cur_hi);
      check({tag, " lo during busy"}, md.LO, cur_lo);
      check({tag, " stall during busy"}, {31'd0, md.MD_Stall}, 32'd1);
      n++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, n, exp_cyc);
    check({tag, " hi"}, md.HI, exp_hi);
    check({tag, " lo"}, md.LO, exp_lo);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total  = 0;
    passed = 0;

    //            op     A              B              HI             LO             cycles
    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MULT_CYCLES};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MULT_CYCLES};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYCLES};
    vecs[3]  = '{3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYCLES};
    vecs[4]  = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 0};
    vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_CYCLES};
    vecs[6]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DIV_CYCLES};
    vecs[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_CYCLES};
    vecs[8]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MULT_CYCLES};
    vecs[9]  = '{3'd5, 32'hCAFEF00D, 32'd0,        32'h3FFFFFFF, 32'hCAFEF00D, 0};
    vecs[10] = '{3'd2, 32'd5,        32'd0,        32'h3FFFFFFF, 32'hCAFEF00D, DIV_CYCLES};
    vecs[11] = '{3'd6, 32'h11111111, 32'd3,        32'h3FFFFFFF, 32'hCAFEF00D, 0};
    vecs[12] = '{3'd7, 32'h22222222, 32'd4,        32'h3FFFFFFF, 32'hCAFEF00D, 0};
    vecs[13] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_CYCLES};
    vecs[14] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MULT_CYCLES};

    // Reset
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset busy", {31'd0, md.MD_Busy}, 32'd0);
    check("reset stall", {31'd0, md.MD_Stall}, 32'd0);
    check("reset hi", md.HI, 32'd0);
    check("reset lo", md.LO, 32'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clk);

    // Table vectors, issued back-to-back
    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cycles);

    // MULT 3*4 with an MTLO and an operand change during busy cycle 2
    md.MD_Op    = 3'd0;
    md.MD_A     = 32'd3;
    md.MD_B     = 32'd4;
    md.MD_Start = 1'b1;
    @(negedge clk);
    n = 0;
    while (md.MD_Busy && n < BUSY_LIMIT) begin
      check("ign hi during busy", md.HI, cur_hi);
      check("ign lo during busy", md.LO, cur_lo);
      n++;
      if (n == 2) begin
        md.MD_Op    = 3'd5;
        md.MD_A     = 32'hDEADBEEF;
        md.MD_B     = 32'd99;
        md.MD_Start = 1'b1;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
    check("ign busy cycles", n, MULT_CYCLES);
    check("ign hi", md.HI, 32'd0);
    check("ign lo", md.LO, 32'd12);
    cur_hi = 32'd0;
    cur_lo = 32'd12;
    @(negedge clk);

    // Back-to-back: DIVU result visible for exactly the issue cycle of the MULT
    run_op("b2b divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYCLES);
    run_op("b2b mult", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, MULT_CYCLES);

    // Reset during busy cycle 4 of a DIV; no late write may follow
    md.MD_Op    = 3'd2;
    md.MD_A     = 32'd100;
    md.MD_B     = 32'd7;
    md.MD_Start = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst-mid busy c4", {31'd0, md.MD_Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst-mid busy", {31'd0, md.MD_Busy}, 32'd0);
    check("rst-mid hi", md.HI, 32'd0);
    check("rst-mid lo", md.LO, 32'd0);
    repeat (DIV_CYCLES + 2) begin
      @(negedge clk);
      check("rst-mid late busy", {31'd0, md.MD_Busy}, 32'd0);
      check("rst-mid late hi", md.HI, 32'd0);
      check("rst-mid late lo", md.LO, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and takes operands from the EX-stage forwarding muxes. It sequences MULT/MULTU/DIV/DIVU through a busy countdown and handles MTHI/MTLO writes. It exports busy/stall status so the hazard unit can freeze any later HI/LO-touching instruction in D.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, synchronous reset
- MD_A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- MD_B  input  32  operand rt (divisor / multiplier)
- MD_Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op
- MD_Start  input  1  request strobe for MD_Op this cycle
- MD_Busy  output  1  registered; high while an operation is in flight
- MD_Stall  output  1  combinational; MD_Busy | (MD_Start & MD_Op ≤ 3)
- HI  output  32  HI register
- LO  output  32  LO register

## Operation

- States: IDLE, BUSY. Internal: down-counter (width fits max(MULT_CYCLES, DIV_CYCLES)), pending HI/LO result registers.
- IDLE, MD_Start=1, MD_Op 0–3:
  - Compute result from MD_A/MD_B; latch into pending.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go BUSY.
- IDLE, MD_Start=1, MD_Op 4: HI ← MD_A at the edge. MD_Op 5: LO ← MD_A at the edge. No BUSY.
- IDLE, MD_Start=1, MD_Op 6–7, or MD_Start=0: no action.
- BUSY:
  - Counter decrements each cycle.
  - On the cycle the counter reads 1: HI/LO ← pending at that edge; go IDLE.
- MD_Start while BUSY, any op, including MTHI/MTLO: ignored completely.
  - The hazard unit guarantees this does not occur; the bench checks it anyway.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder, sign follows dividend.
  - DIV, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (MD_B = 0, DIV or DIVU):
  - Full DIV_CYCLES busy sequence runs.
  - HI and LO keep their prior values.
- Reset, including mid-operation:
  - HI = 0, LO = 0, MD_Busy = 0, state IDLE, counter = 0.
  - Pending result discarded.

## Timing

- Edge E0 ends the cycle with MD_Start=1 and a mult/div op.
  - MD_Busy = 1 in the N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO update at the edge ending the Nth busy cycle.
  - In the following cycle, MD_Busy = 0 and new HI/LO are visible together.
- MD_Stall is high in the Start cycle itself and in all N busy cycles, so the hazard unit never issues a conflicting request.
- A new MD_Start is accepted in the first cycle MD_Busy = 0. There is no dead cycle between back-to-back operations.
- MTHI/MTLO: written HI/LO is visible the cycle after the Start cycle.
- HI/LO are stable (previous values) throughout BUSY.
- Operands are sampled only in the Start cycle. Changes to MD_A/MD_B during BUSY have no effect.

## Test plan

- Reset, then MULT with A=0xFFFFFFFD (−3), B=5 → MD_Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. HI/LO stay 0 during BUSY.
- MULTU with A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. MD_Stall high in the Start cycle and all 5 busy cycles.
- DIV with A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7, B=0 → 10 busy cycles; HI/LO unchanged.
- MTHI A=0x12345678 while IDLE → HI=0x12345678 next cycle. MULT started; MTLO 0xDEADBEEF pulsed during BUSY, and operands changed mid-op → MTLO ignored; result matches the operands sampled at Start.
- Back-to-back: MULT issued the first cycle after a DIV completes → DIV result visible for one cycle, then MULT result after 5 more cycles. No lost or extra busy cycle.
- DIV started, then reset at busy cycle 4 → next cycle MD_Busy=0, HI=LO=0. Remaining countdown produces no late HI/LO write.
